// File: rtl/instr_exec_unit.sv
// Execution stage: walks a range of instruction-register entries, executes each
// signed opcode and delivers one result per entry over a valid/ready handshake.
package instr_register_pkg;
  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;
endpackage

module instr_exec_unit
  import instr_register_pkg::*;
#(
  parameter int NUM_ENTRIES = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  address_t           start_addr_i,
  input  logic [5:0]         count_i,
  output address_t           read_pointer_o,
  input  instruction_t       instruction_word_i,
  output logic               busy_o,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic signed [63:0] result_o,
  output opcode_t            res_opcode_o,
  output address_t           res_addr_o,
  output logic               res_div0_o,
  output logic               done_o
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, OUT} state_t;

  state_t             state_q, state_d;
  address_t           ptr_q, ptr_d;
  address_t           rp_q, rp_d;
  logic [5:0]         remaining_q, remaining_d;
  instruction_t       instr_q, instr_d;
  logic signed [63:0] result_q, result_d;
  opcode_t            res_opcode_q, res_opcode_d;
  address_t           res_addr_q, res_addr_d;
  logic               res_div0_q, res_div0_d;
  logic               res_valid_q, res_valid_d;
  logic               done_q, done_d;

  logic signed [63:0] op_a_ext, op_b_ext, alu_res;
  logic               alu_div0;
  address_t           ptr_inc;

  assign ptr_inc = (ptr_q == address_t'(NUM_ENTRIES - 1)) ? '0 : ptr_q + 1'b1;

  // Operands are widened to 64 bits so MULT and the (-2^31)/(-1) quotient are exact.
  always_comb begin
    op_a_ext = {{32{instr_q.op_a[31]}}, instr_q.op_a};
    op_b_ext = {{32{instr_q.op_b[31]}}, instr_q.op_b};
    alu_res  = '0;
    alu_div0 = 1'b0;
    case (instr_q.opc)
      ZERO:  alu_res = '0;
      PASSA: alu_res = op_a_ext;
      PASSB: alu_res = op_b_ext;
      ADD:   alu_res = op_a_ext + op_b_ext;
      SUB:   alu_res = op_a_ext - op_b_ext;
      MULT:  alu_res = op_a_ext * op_b_ext;
      DIV:   if (op_b_ext == 0) alu_div0 = 1'b1; else alu_res = op_a_ext / op_b_ext;
      MOD:   if (op_b_ext == 0) alu_div0 = 1'b1; else alu_res = op_a_ext % op_b_ext;
      default: alu_res = '0;
    endcase
  end

  // NOTE: every next-state signal takes its hold value first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    rp_d         = rp_q;
    remaining_d  = remaining_q;
    instr_d      = instr_q;
    result_d     = result_q;
    res_opcode_d = res_opcode_q;
    res_addr_d   = res_addr_q;
    res_div0_d   = res_div0_q;
    res_valid_d  = res_valid_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (count_i != '0) begin
            ptr_d       = start_addr_i;
            remaining_d = count_i;
            state_d     = FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FETCH: begin
        rp_d    = ptr_q;
        instr_d = instruction_word_i;
        state_d = EXEC;
      end
      EXEC: begin
        result_d     = alu_res;
        res_opcode_d = instr_q.opc;
        res_addr_d   = ptr_q;
        res_div0_d   = alu_div0;
        res_valid_d  = 1'b1;
        state_d      = OUT;
      end
      OUT: begin
        if (res_valid_q && res_ready_i) begin
          res_valid_d = 1'b0;
          remaining_d = remaining_q - 1'b1;
          ptr_d       = ptr_inc;
          if (remaining_q == 6'd1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      rp_q         <= '0;
      remaining_q  <= '0;
      instr_q      <= '{opc: ZERO, op_a: '0, op_b: '0};
      result_q     <= '0;
      res_opcode_q <= ZERO;
      res_addr_q   <= '0;
      res_div0_q   <= 1'b0;
      res_valid_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      rp_q         <= rp_d;
      remaining_q  <= remaining_d;
      instr_q      <= instr_d;
      result_q     <= result_d;
      res_opcode_q <= res_opcode_d;
      res_addr_q   <= res_addr_d;
      res_div0_q   <= res_div0_d;
      res_valid_q  <= res_valid_d;
      done_q       <= done_d;
    end
  end

  // The live pointer is shown only while fetching; otherwise the last fetched address holds.
  assign read_pointer_o = (state_q == FETCH) ? ptr_q : rp_q;
  assign busy_o         = (state_q != IDLE);
  assign res_valid_o    = res_valid_q;
  assign result_o       = result_q;
  assign res_opcode_o   = res_opcode_q;
  assign res_addr_o     = res_addr_q;
  assign res_div0_o     = res_div0_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_instr_exec_unit.sv
// Directed bench for instr_exec_unit: an instruction-register model feeds the DUT
// and hand-computed results are checked with immediate assertions.
module tb_instr_exec_unit;
  import instr_register_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  address_t           start_addr;
  logic [5:0]         count;
  address_t           read_pointer;
  instruction_t       instruction_word;
  logic               busy;
  logic               res_valid;
  logic               res_ready;
  logic signed [63:0] result;
  opcode_t            res_opcode;
  address_t           res_addr;
  logic               res_div0;
  logic               done;

  instruction_t mem [32];
  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int d0;

  always #5 clk = ~clk;

  assign instruction_word = mem[read_pointer];

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  instr_exec_unit #(.NUM_ENTRIES(32)) dut (
    .clk_i              (clk),
    .reset_i            (reset),
    .start_i            (start),
    .start_addr_i       (start_addr),
    .count_i            (count),
    .read_pointer_o     (read_pointer),
    .instruction_word_i (instruction_word),
    .busy_o             (busy),
    .res_valid_o        (res_valid),
    .res_ready_i        (res_ready),
    .result_o           (result),
    .res_opcode_o       (res_opcode),
    .res_addr_o         (res_addr),
    .res_div0_o         (res_div0),
    .done_o             (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_entry(input int idx, input opcode_t opc, input operand_t a, input operand_t b);
    mem[idx] = '{opc: opc, op_a: a, op_b: b};
  endtask

  task automatic begin_run(input address_t addr, input logic [5:0] cnt);
    start = 1'b1;
    start_addr = addr;
    count = cnt;
    tick();
    start = 1'b0;
  endtask

  // Called while in FETCH with res_ready high; ends just after the handshake edge.
  task automatic run_one(input string tag, input address_t addr, input logic [63:0] exp_res,
                         input opcode_t opc, input logic div0);
    check({tag, "_rp"}, 64'(read_pointer), 64'(addr));
    tick();
    check({tag, "_valid_early"}, 64'(res_valid), 64'd0);
    tick();
    check({tag, "_valid"}, 64'(res_valid), 64'd1);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_opc"}, 64'(res_opcode), 64'(opc));
    check({tag, "_addr"}, 64'(res_addr), 64'(addr));
    check({tag, "_div0"}, 64'(res_div0), 64'(div0));
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rp"}, 64'(read_pointer), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_result"}, result, 64'd0);
    check({tag, "_opc"}, 64'(res_opcode), 64'(ZERO));
    check({tag, "_addr"}, 64'(res_addr), 64'd0);
    check({tag, "_div0"}, 64'(res_div0), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '{opc: ZERO, op_a: '0, op_b: '0};
    set_entry(0, ADD, 32'sd5, 32'sd3);
    set_entry(1, SUB, 32'sd5, 32'sd8);
    set_entry(2, MULT, -32'sd7, 32'sd6);
    set_entry(3, PASSB, 32'sd1, -32'sd1);
    set_entry(4, MULT, 32'h7FFFFFFF, 32'h7FFFFFFF);
    set_entry(5, DIV, -32'sd7, 32'sd2);
    set_entry(6, MOD, -32'sd7, 32'sd2);
    set_entry(7, DIV, 32'h80000000, -32'sd1);
    set_entry(8, DIV, 32'sd9, 32'sd0);
    set_entry(9, MOD, 32'sd9, 32'sd0);
    set_entry(10, DIV, 32'sd9, 32'sd3);
    set_entry(30, ADD, 32'sd1, 32'sd1);
    set_entry(31, PASSA, -32'sd9, 32'sd4);

    reset = 1'b1; start = 1'b0; start_addr = '0; count = '0; res_ready = 1'b0;
    tick(); tick();
    check_reset_outputs("por");
    reset = 1'b0;
    tick();

    // Basic four-entry run, ready asserted before valid.
    res_ready = 1'b1;
    d0 = done_cnt;
    begin_run(5'd0, 6'd4);
    check("run1_busy", 64'(busy), 64'd1);
    run_one("r1e0", 5'd0, 64'sd8, ADD, 1'b0);
    run_one("r1e1", 5'd1, -64'sd3, SUB, 1'b0);
    run_one("r1e2", 5'd2, -64'sd42, MULT, 1'b0);
    run_one("r1e3", 5'd3, -64'sd1, PASSB, 1'b0);
    check("run1_done_hi", 64'(done), 64'd1);
    check("run1_busy_lo", 64'(busy), 64'd0);
    tick();
    check("run1_done_lo", 64'(done), 64'd0);
    check("run1_rp_hold", 64'(read_pointer), 64'd3);
    tick(); tick();
    check("run1_done_once", 64'(done_cnt - d0), 64'd1);

    // Arithmetic corner cases and divide by zero.
    begin_run(5'd4, 6'd7);
    run_one("mult_max", 5'd4, 64'h3FFFFFFF00000001, MULT, 1'b0);
    run_one("div_neg", 5'd5, -64'sd3, DIV, 1'b0);
    run_one("mod_neg", 5'd6, -64'sd1, MOD, 1'b0);
    run_one("div_min", 5'd7, 64'h0000000080000000, DIV, 1'b0);
    run_one("div_zero", 5'd8, 64'd0, DIV, 1'b1);
    run_one("mod_zero", 5'd9, 64'd0, MOD, 1'b1);
    run_one("div_ok", 5'd10, 64'sd3, DIV, 1'b0);
    check("run2_done", 64'(done), 64'd1);
    tick();

    // Pointer wrap 30, 31, 0, 1.
    begin_run(5'd30, 6'd4);
    run_one("wrap30", 5'd30, 64'sd2, ADD, 1'b0);
    run_one("wrap31", 5'd31, -64'sd9, PASSA, 1'b0);
    run_one("wrap0", 5'd0, 64'sd8, ADD, 1'b0);
    run_one("wrap1", 5'd1, -64'sd3, SUB, 1'b0);
    check("wrap_done", 64'(done), 64'd1);
    tick();

    // Backpressure with a start pulse while busy.
    res_ready = 1'b0;
    begin_run(5'd2, 6'd1);
    tick(); tick();
    check("bp_valid", 64'(res_valid), 64'd1);
    start = 1'b1; start_addr = 5'd10; count = 6'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      start = 1'b0;
      check("bp_hold_valid", 64'(res_valid), 64'd1);
      check("bp_hold_result", result, -64'sd42);
      check("bp_hold_opc", 64'(res_opcode), 64'(MULT));
      check("bp_hold_addr", 64'(res_addr), 64'd2);
      check("bp_hold_rp", 64'(read_pointer), 64'd2);
    end
    res_ready = 1'b1;
    tick();
    check("bp_done", 64'(done), 64'd1);
    check("bp_valid_lo", 64'(res_valid), 64'd0);
    tick();
    check("bp_no_restart", 64'(busy), 64'd0);

    // Zero-length run.
    begin_run(5'd7, 6'd0);
    check("cnt0_done", 64'(done), 64'd1);
    check("cnt0_busy", 64'(busy), 64'd0);
    check("cnt0_valid", 64'(res_valid), 64'd0);
    tick();
    check("cnt0_done_lo", 64'(done), 64'd0);

    // Asynchronous reset while holding a result.
    res_ready = 1'b0;
    begin_run(5'd1, 6'd4);
    tick(); tick();
    check("rst_pre_valid", 64'(res_valid), 64'd1);
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_rst");
    d0 = done_cnt;
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    check("rst_no_done", 64'(done_cnt - d0), 64'd0);
    check("rst_idle", 64'(busy), 64'd0);
    res_ready = 1'b1;
    begin_run(5'd0, 6'd1);
    run_one("post_rst", 5'd0, 64'sd8, ADD, 1'b0);
    check("post_rst_done", 64'(done), 64'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
